// File: rtl/muldiv_hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes, FSM states, iteration count.
// Helpers classify an operation as divide and/or signed.
package muldiv_hilo_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_abs_neg.sv
// Conditional two's-complement negate; purely combinational, zero latency, no flow control.
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    assign out = neg_en ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO; WIDTH+1 edges per op (MULT/MULTU 1 edge with MULDIV_FAST_MULT_EN).
// No queueing: start_i and MTHI/MTLO writes are ignored while busy_o is high.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    op_e              op_q;
    logic             sa, sb;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    op_e              op_in;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_in = op_e'(op_i);
    assign neg_a = op_is_signed(op_in) & a_i[WIDTH-1];
    assign neg_b = op_is_signed(op_in) & b_i[WIDTH-1];

    muldiv_abs_neg #(.W(WIDTH)) u_abs_a (.in(a_i), .neg_en(neg_a), .out(abs_a));
    muldiv_abs_neg #(.W(WIDTH)) u_abs_b (.in(b_i), .neg_en(neg_b), .out(abs_b));

    // Multiply: add |a| into the upper half when the multiplier LSB is set, then shift right.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = acc_hi + ({1'b0, opa} & {(WIDTH+1){acc_lo[0]}});

    // Divide: shift the next dividend bit into a WIDTH+1 remainder and keep the trial difference if non-negative.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             div_ge;
    assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, opb};
    assign div_ge    = ~div_trial[WIDTH+1];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

    logic               div0;
    logic [WIDTH-1:0]   rem_src, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // A zero divisor reports the raw dividend in HI: |a| re-negated by the dividend sign.
    assign div0    = op_is_div(op_q) && (opb == '0);
    assign rem_src = div0 ? opa : acc_hi[WIDTH-1:0];

    muldiv_abs_neg #(.W(2*WIDTH)) u_fix_prod (.in({acc_hi[WIDTH-1:0], acc_lo}), .neg_en(sa ^ sb), .out(prod_fix));
    muldiv_abs_neg #(.W(WIDTH))   u_fix_quo  (.in(acc_lo),  .neg_en(sa ^ sb), .out(quo_fix));
    muldiv_abs_neg #(.W(WIDTH))   u_fix_rem  (.in(rem_src), .neg_en(sa),      .out(rem_fix));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_MULT;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q <= op_in;
                        sa   <= neg_a;
                        sb   <= neg_b;
                        opa  <= abs_a;
                        opb  <= abs_b;
                        cnt  <= '0;
`ifdef MULDIV_FAST_MULT_EN
                        if (!op_is_div(op_in)) begin
                            acc_hi <= {1'b0, fast_prod[2*WIDTH-1:WIDTH]};
                            acc_lo <= fast_prod[WIDTH-1:0];
                            state  <= ST_FIX;
                        end else
`endif
                        begin
                            acc_hi <= '0;
                            acc_lo <= op_is_div(op_in) ? abs_a : abs_b;
                            state  <= ST_CALC;
                        end
                    end else begin
                        if (mthi_i) hi_o <= a_i;
                        if (mtlo_i) lo_o <= a_i;
                    end
                end
                ST_CALC: begin
                    if (op_is_div(op_q)) begin
                        acc_hi <= div_ge ? div_trial[WIDTH:0] : div_shift;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (op_is_div(op_q)) begin
                        hi_o <= rem_fix;
                        lo_o <= div0 ? '1 : quo_fix;
                    end else begin
                        {hi_o, lo_o} <= prod_fix;
                    end
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized and directed checks of muldiv_hilo against an arithmetic reference model.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .mthi_i(mthi), .mtlo_i(mtlo), .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference results {hi, lo} straight from the MIPS arithmetic rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy;
        longint      lx, ly;
        logic [63:0] ux, uy;
        ix = x; iy = y; lx = ix; ly = iy; ux = {32'h0, x}; uy = {32'h0, y};
        case (o)
            2'b00: return lx * ly;
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        if (o == 2'b00 || o == 2'b01) return 1;
`endif
        return 33;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        if (!done) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int          n;
        e = model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat(o)));
        check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi0, lo0;
        logic [63:0] e;
        int          n, pulses;

        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_5_0", 2'b11, 32'd5, 32'd0);
        run_op("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);

        // A second start plus MT writes while busy must not disturb the running divide.
        hi0 = hi; lo0 = lo;
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        op = 2'b00; a = 32'd9; b = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("busy_hold_hi", 64'(hi), 64'(hi0));
        check("busy_hold_lo", 64'(lo), 64'(lo0));
        wait_done(n);
        if (done) pulses++;
        check("busy_lat", 64'(n + 5), 64'd33);
        e = model(2'b11, 32'd100, 32'd7);
        check("busy_hi", 64'(hi), 64'(e[63:32]));
        check("busy_lo", 64'(lo), 64'(e[31:0]));
        repeat (5) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);

        lo0 = lo;
        mthi = 1'b1; a = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'(lo0));
        mthi = 1'b1; mtlo = 1'b1; a = 32'h55AA_0F0F;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", 64'(hi), 64'h55AA_0F0F);
        check("mtboth_lo", 64'(lo), 64'h55AA_0F0F);

        // start wins over a simultaneous MT write.
        hi0 = hi;
        op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1; mthi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("startwin_hi", 64'(hi), 64'(hi0));
        wait_done(n);
        check("startwin_lo", 64'(lo), 64'd42);
        check("startwin_hi2", 64'(hi), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an iteration.
        op = 2'b11; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_stay_idle", 64'(busy), 64'd0);
        run_op("post_rst_6x7", 2'b01, 32'd6, 32'd7);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
